regfile_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_read_port.sv | 37 +++
 rtl/regfile_param.sv | 95 +++++++++
 tb/tb_regfile_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the parametrised register file.
package regfile_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_NUM_READ   = 2;
    localparam int REG_ZERO           = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, write-first bypass and busy gating.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]      rd_idx,
    input  logic [DATA_WIDTH-1:0]      regs [2**ADDR_WIDTH],
    input  logic [2**ADDR_WIDTH-1:0]   busy_vec,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_busy
);

    logic hit;
    logic is_zero;

    assign hit     = wr_en && (wr_idx == rd_idx);
    assign is_zero = (rd_idx == ADDR_WIDTH'(REG_ZERO));

    // Register 0 overrides the bypass so a discarded write never leaks through.
    always_comb begin
        rd_data = regs[rd_idx];
        rd_busy = busy_vec[rd_idx] & ~hit;
        if (hit) begin
            rd_data = wr_data;
        end
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with bypass, busy scoreboard and registered debug tap.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int NUM_READ   = REGFILE_NUM_READ
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            busy_readReg,
    input  logic                           ctrl_busySet,
    input  logic [ADDR_WIDTH-1:0]          ctrl_busyReg,
    input  logic [ADDR_WIDTH-1:0]          ctrl_dbgReg,
    output logic [DATA_WIDTH-1:0]          data_dbgReg
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DATA_WIDTH-1:0] dbg_q;
    logic [DATA_WIDTH-1:0] dbg_next;
    logic                  wr_ok;

    assign wr_ok = ctrl_writeEnable && (ctrl_writeReg != ADDR_WIDTH'(REG_ZERO));

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // A set beats a same-edge write: the newer long-latency op is still in flight.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy <= '0;
        end else begin
            for (int r = REG_ZERO + 1; r < DEPTH; r++) begin
                if (ctrl_busySet && (ctrl_busyReg == ADDR_WIDTH'(r))) begin
                    busy[r] <= 1'b1;
                end else if (ctrl_writeEnable && (ctrl_writeReg == ADDR_WIDTH'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Sample the post-edge content, so a same-cycle write is folded in.
    always_comb begin
        dbg_next = regs[ctrl_dbgReg];
        if (wr_ok && (ctrl_writeReg == ctrl_dbgReg)) begin
            dbg_next = data_writeReg;
        end
        if (ctrl_dbgReg == ADDR_WIDTH'(REG_ZERO)) begin
            dbg_next = '0;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_next;
        end
    end

    assign data_dbgReg = dbg_q;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_port (
            .rd_idx   (ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .regs     (regs),
            .busy_vec (busy),
            .wr_en    (ctrl_writeEnable),
            .wr_idx   (ctrl_writeReg),
            .wr_data  (data_writeReg),
            .rd_data  (data_readReg[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_busy  (busy_readReg[p])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build plus a 4-port 16x8 build.
module tb_regfile_param;

    logic clock = 1'b0;
    logic ctrl_reset;
    always #5 clock = ~clock;

    // Default build (32 bit, 32 regs, 2 ports)
    logic        a_we;
    logic [4:0]  a_wr;
    logic [31:0] a_wd;
    logic [9:0]  a_rd;
    logic [63:0] a_rdata;
    logic [1:0]  a_busy;
    logic        a_bset;
    logic [4:0]  a_breg;
    logic [4:0]  a_dbg;
    logic [31:0] a_dbgdata;

    regfile_param u_a (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (a_we),
        .ctrl_writeReg    (a_wr),
        .data_writeReg    (a_wd),
        .ctrl_readReg     (a_rd),
        .data_readReg     (a_rdata),
        .busy_readReg     (a_busy),
        .ctrl_busySet     (a_bset),
        .ctrl_busyReg     (a_breg),
        .ctrl_dbgReg      (a_dbg),
        .data_dbgReg      (a_dbgdata)
    );

    // Narrow build (16 bit, 8 regs, 4 ports)
    logic        b_we;
    logic [2:0]  b_wr;
    logic [15:0] b_wd;
    logic [11:0] b_rd;
    logic [63:0] b_rdata;
    logic [3:0]  b_busy;
    logic        b_bset;
    logic [2:0]  b_breg;
    logic [2:0]  b_dbg;
    logic [15:0] b_dbgdata;

    regfile_param #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3),
        .NUM_READ   (4)
    ) u_b (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (b_we),
        .ctrl_writeReg    (b_wr),
        .data_writeReg    (b_wd),
        .ctrl_readReg     (b_rd),
        .data_readReg     (b_rdata),
        .busy_readReg     (b_busy),
        .ctrl_busySet     (b_bset),
        .ctrl_busyReg     (b_breg),
        .ctrl_dbgReg      (b_dbg),
        .data_dbgReg      (b_dbgdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        bset;
        logic [4:0]  breg;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [4:0]  dbg;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] dbg_post;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           we    wr     wd             bset  breg   rd0    rd1    dbg    d0             d1             b0    b1    dbg_post
        vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h12345678};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h12345678};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd7,  5'd9,  32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1, 32'h12345678};
        vecs[6]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678};
        vecs[8]  = '{1'b1, 5'd3,  32'h00000011, 1'b1, 5'd3,  5'd3,  5'd9,  5'd3,  32'h00000011, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h00000011};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  5'd3,  32'h00000011, 32'h00000011, 1'b1, 1'b1, 32'h00000011};
        vecs[10] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd1,  5'd5,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd3,  5'd0,  32'hDEADBEEF, 32'h00000011, 1'b0, 1'b1, 32'h0};

        ctrl_reset = 1'b1;
        a_we = 1'b0; a_wr = '0; a_wd = '0; a_rd = '0; a_bset = 1'b0; a_breg = '0; a_dbg = '0;
        b_we = 1'b0; b_wr = '0; b_wd = '0; b_rd = '0; b_bset = 1'b0; b_breg = '0; b_dbg = '0;
        tick();
        tick();
        ctrl_reset = 1'b0;
        a_rd = {5'd7, 5'd5};
        #1;
        check("reset_a_rdata", a_rdata, 64'h0);
        check("reset_a_busy", a_busy, 2'b00);
        check("reset_a_dbg", a_dbgdata, 32'h0);
        tick();

        for (int i = 0; i < 12; i++) begin
            a_we = vecs[i].we;  a_wr = vecs[i].wr;  a_wd = vecs[i].wd;
            a_bset = vecs[i].bset; a_breg = vecs[i].breg;
            a_rd = {vecs[i].rd1, vecs[i].rd0};
            a_dbg = vecs[i].dbg;
            #2;
            check($sformatf("row%0d_d0", i), a_rdata[31:0], vecs[i].d0);
            check($sformatf("row%0d_d1", i), a_rdata[63:32], vecs[i].d1);
            check($sformatf("row%0d_busy", i), a_busy, {vecs[i].b1, vecs[i].b0});
            tick();
            check($sformatf("row%0d_dbg", i), a_dbgdata, vecs[i].dbg_post);
        end

        // Asynchronous reset between edges wipes storage, busy and the tap at once
        a_we = 1'b0; a_bset = 1'b0; a_dbg = 5'd5;
        a_rd = {5'd3, 5'd5};
        tick();
        check("prereset_d0", a_rdata[31:0], 32'hDEADBEEF);
        check("prereset_b1", a_busy, 2'b10);
        check("prereset_dbg", a_dbgdata, 32'hDEADBEEF);
        #2;
        ctrl_reset = 1'b1;
        #1;
        check("async_reset_rdata", a_rdata, 64'h0);
        check("async_reset_busy", a_busy, 2'b00);
        check("async_reset_dbg", a_dbgdata, 32'h0);

        // A write presented while reset is held is lost
        a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hCAFEF00D;
        tick();
        ctrl_reset = 1'b0;
        a_we = 1'b0;
        #1;
        check("write_lost_in_reset", a_rdata[31:0], 32'h0);
        a_we = 1'b1; a_wr = 5'd5; a_wd = 32'h0BADF00D;
        tick();
        a_we = 1'b0;
        #1;
        check("first_write_after_reset", a_rdata[31:0], 32'h0BADF00D);

        // Narrow 4-port build: debug tap latency and shared-index reads
        b_we = 1'b1; b_wr = 3'd2; b_wd = 16'hBEEF; b_dbg = 3'd0;
        tick();
        b_we = 1'b0;
        b_dbg = 3'd2;
        b_rd = {3'd2, 3'd2, 3'd2, 3'd2};
        #1;
        check("b_dbg_before_edge", b_dbgdata, 16'h0);
        check("b_ports_all_2", b_rdata, 64'hBEEF_BEEF_BEEF_BEEF);
        check("b_busy_all_2", b_busy, 4'b0000);
        tick();
        check("b_dbg_one_edge", b_dbgdata, 16'hBEEF);

        // Narrow build: busy set then cleared by a write, port 3 only
        b_bset = 1'b1; b_breg = 3'd6;
        b_rd = {3'd6, 3'd2, 3'd0, 3'd2};
        tick();
        b_bset = 1'b0;
        #1;
        check("b_busy_set6", b_busy, 4'b1000);
        b_we = 1'b1; b_wr = 3'd6; b_wd = 16'h1234;
        #1;
        check("b_bypass6_busy", b_busy, 4'b0000);
        check("b_bypass6_data", b_rdata[63:48], 16'h1234);
        tick();
        b_we = 1'b0;
        #1;
        check("b_stored6_busy", b_busy, 4'b0000);
        check("b_stored6_data", b_rdata, 64'h1234_BEEF_0000_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
